uart_rx_frame: RTL

- 8N1 UART receiver that decodes the serial line driven by the SoC's UART_TXD pin.
- Presents received bytes on a valid/ready byte interface.
- Used in simulation and on-board loopback to check SoC console output; also reusable as the SoC-side receive path feeding UART_RXD logic.
- Fixed bit period in clocks, mid-bit sampling, framing and overrun detection.

---
 rtl/uart_rx_frame.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx_frame.sv
// uart_rx_frame
// -------------
// 8N1 UART receiver. The serial line is synchronised, then decoded by a
// five-state FSM (IDLE, START, DATA, STOP, BREAK). Samples are taken at a
// fixed number of clocks from the start-bit falling edge: half a bit period
// to confirm the start bit, then one full bit period per data bit and for
// the stop bit. Received bytes appear on a valid/ready byte interface.
//
// Ports
//   iCLK      system clock
//   iRST      synchronous active-low reset (0 = reset)
//   UART_RXD  serial line, idle high, LSB first
//   oDATA     received byte, held while oVALID=1 (except on overrun)
//   oVALID    byte available
//   iREADY    consumer accepts when oVALID & iREADY at a rising edge
//   oFERR     one-cycle pulse: stop bit sampled low
//   oOVR      one-cycle pulse: byte completed while previous one unaccepted
//   oBUSY     receiver is in any state other than IDLE
//
// Parameters
//   BAUD_DIV     clocks per bit, 8..65535
//   SYNC_STAGES  input synchroniser depth, 2..3

`timescale 1ns/1ps

module uart_rx_frame #(
  parameter int BAUD_DIV    = 868,
  parameter int SYNC_STAGES = 2
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       UART_RXD,
  output logic [7:0] oDATA,
  output logic       oVALID,
  input  logic       iREADY,
  output logic       oFERR,
  output logic       oOVR,
  output logic       oBUSY
);

  localparam logic [15:0] BIT_LAST  = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'((BAUD_DIV / 2) - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] sync;
  logic                   rxs;
  logic [15:0]            cnt, cnt_n;
  logic [2:0]             bi, bi_n;
  logic [7:0]             shreg, shreg_n;
  logic [7:0]             data_n;
  logic                   vld_n;
  logic                   ferr_n;
  logic                   ovr_n;

  // Synchroniser output; the flops reset to the idle (high) line level so
  // that a reset never looks like a start bit.
  assign rxs   = sync[SYNC_STAGES-1];
  assign oBUSY = (state != S_IDLE);

  // Control and output registers
  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      sync   <= '1;
      state  <= S_IDLE;
      cnt    <= '0;
      bi     <= '0;
      oDATA  <= '0;
      oVALID <= 1'b0;
      oFERR  <= 1'b0;
      oOVR   <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], UART_RXD};
      state  <= state_n;
      cnt    <= cnt_n;
      bi     <= bi_n;
      oDATA  <= data_n;
      oVALID <= vld_n;
      oFERR  <= ferr_n;
      oOVR   <= ovr_n;
    end
  end

  // Shift register holds only in-flight data; it is fully rewritten by
  // every frame before it can reach oDATA, so it needs no reset.
  always_ff @(posedge iCLK) begin
    shreg <= shreg_n;
  end

  // Next-state and datapath decode
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bi_n    = bi;
    shreg_n = shreg;
    data_n  = oDATA;
    vld_n   = oVALID;
    ferr_n  = 1'b0;
    ovr_n   = 1'b0;

    // Consumer handshake; a byte completing on this same edge overrides
    // the clear below, giving valid=1 with the new data and no overrun.
    if (oVALID && iREADY) begin
      vld_n = 1'b0;
    end

    case (state)
      S_IDLE: begin
        if (!rxs) begin
          state_n = S_START;
          cnt_n   = '0;
        end
      end

      S_START: begin
        if (cnt == HALF_LAST) begin
          // Line back high at mid start bit: treat as a glitch.
          state_n = rxs ? S_IDLE : S_DATA;
          cnt_n   = '0;
          bi_n    = '0;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end

      S_DATA: begin
        if (cnt == BIT_LAST) begin
          shreg_n[bi] = rxs;
          cnt_n       = '0;
          if (bi == 3'd7) begin
            state_n = S_STOP;
          end else begin
            bi_n = bi + 3'd1;
          end
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end

      S_STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n = '0;
          if (rxs) begin
            data_n  = shreg;
            vld_n   = 1'b1;
            state_n = S_IDLE;
            if (oVALID && !iREADY) begin
              ovr_n = 1'b1;
            end
          end else begin
            // Bad stop bit: drop the byte and wait out a possible break.
            ferr_n  = 1'b1;
            state_n = S_BREAK;
          end
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end

      S_BREAK: begin
        if (rxs) begin
          state_n = S_IDLE;
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

endmodule
